apb_conv: RTL and testbench

APB_CONV -- requirements
Module: apb_conv

---
 rtl/apb_conv.sv | 255 +++++++++++++++++++++++++
 tb/tb_apb_conv.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_conv.sv
// apb_conv: APB-mapped 5x5 convolution engine over a 28x28 3-bit image.
// Build option: define APB_CONV_SATURATE_EN to clamp results at 255.
module apb_conv (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);
  localparam logic [11:0] A_CTRL = 12'h500;
  localparam logic [11:0] A_STAT = 12'h504;
  localparam logic [11:0] A_IFM  = 12'h508;
  localparam logic [11:0] A_RIDX = 12'h50C;
  localparam logic [11:0] A_RES  = 12'h510;
  localparam logic [11:0] A_F0   = 12'h900;
  localparam logic [11:0] A_F1   = 12'h904;
  localparam logic [11:0] A_F2   = 12'h908;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SKIP
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [29:0] r_filt0;
  logic [29:0] r_filt1;
  logic [14:0] r_filt2;
  logic [2:0]  r_rowbuf [8][28];
  logic [4:0]  r_rows;
  logic [4:0]  r_orow;
  logic [4:0]  r_col;
  logic [1:0]  r_widx;
  logic        r_row_done;
  logic        r_chan_done;
  logic [9:0]  r_ridx;
  logic [7:0]  r_mem [784];

  logic [11:0] w_off;
  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic        w_busy;
  logic        w_is_ctrl;
  logic        w_is_stat;
  logic        w_is_ifm;
  logic        w_is_ridx;
  logic        w_is_res;
  logic        w_is_filt;
  logic        w_go;
  logic        w_we;
  logic        w_row_end;
  logic        w_fin;
  logic        w_skip_done;
  logic [9:0]  w_waddr;
  logic [10:0] w_sum;
  logic [7:0]  w_res;
  logic [7:0]  w_rdat;
  logic [2:0]  w_wt [5][5];
  logic        w_unused;

  assign w_unused = ^{PADDR[31:12], PWDATA[31:30]};

  assign w_off     = PADDR[11:0];
  assign w_acc     = PSEL & PENABLE & ~HRESETn;
  assign w_wr      = w_acc & PWRITE;
  assign w_rd      = w_acc & ~PWRITE;
  assign w_busy    = (r_state == S_CALC);
  assign w_is_ctrl = (w_off == A_CTRL);
  assign w_is_stat = (w_off == A_STAT);
  assign w_is_ifm  = (w_off == A_IFM);
  assign w_is_ridx = (w_off == A_RIDX);
  assign w_is_res  = (w_off == A_RES);
  assign w_is_filt = (w_off == A_F0) | (w_off == A_F1) | (w_off == A_F2);
  assign w_go      = w_wr & w_is_ctrl & PWDATA[0] & ~w_busy;
  assign w_waddr   = 10'(r_orow) * 10'd28 + 10'(r_col);

  // Row r needs its two lower neighbours loaded (or the image end).
  function automatic logic f_ready(input logic [4:0] row,
                                   input logic [4:0] have);
    logic [5:0] need;
    need = (row > 5'd25) ? 6'd28 : 6'(row) + 6'd3;
    return (row <= 5'd27) && (6'(have) >= need);
  endfunction

  always_comb begin
    for (int j = 0; j < 5; j++) begin
      w_wt[0][j] = r_filt0[29-3*j -: 3];
      w_wt[1][j] = r_filt0[14-3*j -: 3];
      w_wt[2][j] = r_filt1[29-3*j -: 3];
      w_wt[3][j] = r_filt1[14-3*j -: 3];
      w_wt[4][j] = r_filt2[14-3*j -: 3];
    end
  end

  // Rows outside the image are zero padding; row slot is row mod 8.
  always_comb begin
    int ri;
    int cj;
    w_sum = '0;
    ri = 0;
    cj = 0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        ri = int'(r_orow) + i - 2;
        cj = int'(r_col) + j - 2;
        if (ri >= 0 && ri < 28 && cj >= 0 && cj < 28)
          w_sum = w_sum + 11'(w_wt[i][j]) *
                  11'(r_rowbuf[ri[2:0]][cj[4:0]]);
      end
    end
  end

`ifdef APB_CONV_SATURATE_EN
  assign w_res = (w_sum > 11'd255) ? 8'hFF : w_sum[7:0];
`else
  assign w_res = w_sum[7:0];
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_we        = 1'b0;
    w_row_end   = 1'b0;
    w_fin       = 1'b0;
    w_skip_done = 1'b0;
    unique case (r_state)
      S_IDLE, S_SKIP: begin
        w_skip_done = (r_state == S_SKIP) & ~w_go;
        if (w_go)
          w_state_nx = f_ready(r_orow, r_rows) ? S_CALC : S_SKIP;
        else
          w_state_nx = S_IDLE;
      end
      S_CALC: begin
        w_we = 1'b1;
        if (r_col == 5'd27) begin
          w_row_end = 1'b1;
          if (!f_ready(r_orow + 5'd1, r_rows)) begin
            w_fin      = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      r_state     <= S_IDLE;
      r_filt0     <= '0;
      r_filt1     <= '0;
      r_filt2     <= '0;
      r_rows      <= '0;
      r_orow      <= '0;
      r_col       <= '0;
      r_widx      <= '0;
      r_row_done  <= 1'b0;
      r_chan_done <= 1'b0;
      r_ridx      <= '0;
      for (int s = 0; s < 8; s++)
        for (int p = 0; p < 28; p++)
          r_rowbuf[s][p] <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_go) begin
        r_row_done <= 1'b0;
        r_col      <= '0;
      end
      if (w_skip_done || w_fin)
        r_row_done <= 1'b1;
      if (w_fin && r_orow == 5'd27)
        r_chan_done <= 1'b1;
      if (w_we)
        r_col <= w_row_end ? 5'd0 : r_col + 5'd1;
      if (w_row_end)
        r_orow <= r_orow + 5'd1;
      if (w_wr && !w_busy && w_off == A_F0) begin
        r_filt0     <= PWDATA[29:0];
        r_rows      <= '0;
        r_widx      <= '0;
        r_orow      <= '0;
        r_row_done  <= 1'b0;
        r_chan_done <= 1'b0;
      end
      if (w_wr && !w_busy && w_off == A_F1)
        r_filt1 <= PWDATA[29:0];
      if (w_wr && !w_busy && w_off == A_F2)
        r_filt2 <= PWDATA[14:0];
      if (w_wr && !w_busy && w_is_ifm && r_rows != 5'd28) begin
        unique case (r_widx)
          2'd0:
            for (int k = 0; k < 10; k++)
              r_rowbuf[r_rows[2:0]][k] <= PWDATA[29-3*k -: 3];
          2'd1:
            for (int k = 0; k < 10; k++)
              r_rowbuf[r_rows[2:0]][10+k] <= PWDATA[29-3*k -: 3];
          default:
            for (int k = 0; k < 8; k++)
              r_rowbuf[r_rows[2:0]][20+k] <= PWDATA[23-3*k -: 3];
        endcase
        if (r_widx == 2'd2) begin
          r_widx <= '0;
          r_rows <= r_rows + 5'd1;
        end else begin
          r_widx <= r_widx + 2'd1;
        end
      end
      if (w_wr && w_is_ridx)
        r_ridx <= PWDATA[9:0];
      else if (w_rd && w_is_res)
        r_ridx <= (r_ridx >= 10'd783) ? 10'd0 : r_ridx + 10'd1;
    end
  end

  // Result memory is not reset; writes only happen while computing.
  always_ff @(posedge HCLK) begin
    if (w_we)
      r_mem[w_waddr] <= w_res;
  end

  assign w_rdat = (r_ridx < 10'd784) ? r_mem[r_ridx] : 8'd0;
  assign PREADY = 1'b1;

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (w_acc) begin
      unique case (1'b1)
        w_is_stat: begin
          if (PWRITE) PSLVERR = 1'b1;
          else PRDATA = {29'd0, r_chan_done, r_row_done, w_busy};
        end
        w_is_res: begin
          if (PWRITE) PSLVERR = 1'b1;
          else PRDATA = {24'd0, w_rdat};
        end
        w_is_ridx: begin
          if (!PWRITE) PRDATA = {22'd0, r_ridx};
        end
        w_is_ctrl, w_is_ifm, w_is_filt: begin
          if (!PWRITE) PSLVERR = 1'b1;
        end
        default: PSLVERR = 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_conv.sv
// tb_apb_conv: randomized and directed checks of apb_conv against
// a direct convolution model of the image, filter and result memory.
module tb_apb_conv;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_conv dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  int W [5][5];
  int X [28][28];
  int exp_mem [784];
  int m_rows, m_next;
  bit m_rdone, m_cdone;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [11:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic err);
    logic [31:0] rnd;
    rnd = $urandom();
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = {rnd[19:0], a}; PWDATA = d;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1;
    rd = PRDATA; err = PSLVERR;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] rd; logic err;
    xfer(1'b1, a, d, rd, err);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a,
                        input logic [31:0] exp);
    logic [31:0] rd; logic err;
    xfer(1'b0, a, 32'd0, rd, err);
    chk(tag, {err, rd[30:0]}, exp);
  endtask

  function automatic int red(input int s);
`ifdef APB_CONV_SATURATE_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  function automatic int conv(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (r+i-2 >= 0 && r+i-2 < 28 && c+j-2 >= 0 && c+j-2 < 28)
          s += W[i][j] * X[r+i-2][c+j-2];
    return red(s);
  endfunction

  function automatic bit can_run(input int r);
    int need = (r + 3 > 28) ? 28 : r + 3;
    return (r <= 27) && (m_rows >= need);
  endfunction

  task automatic load_filters();
    logic [31:0] f0, f1, f2;
    f0 = '0; f1 = '0; f2 = '0;
    for (int j = 0; j < 5; j++) begin
      f0[29-3*j -: 3] = 3'(W[0][j]);
      f0[14-3*j -: 3] = 3'(W[1][j]);
      f1[29-3*j -: 3] = 3'(W[2][j]);
      f1[14-3*j -: 3] = 3'(W[3][j]);
      f2[14-3*j -: 3] = 3'(W[4][j]);
    end
    wr(12'h900, f0);
    wr(12'h904, f1);
    wr(12'h908, f2);
    m_rows = 0; m_next = 0; m_rdone = 0; m_cdone = 0;
  endtask

  task automatic load_row(input int k);
    logic [31:0] w0, w1, w2;
    w0 = '0; w1 = '0; w2 = '0;
    for (int p = 0; p < 10; p++) begin
      w0[29-3*p -: 3] = 3'(X[k][p]);
      w1[29-3*p -: 3] = 3'(X[k][10+p]);
    end
    for (int p = 0; p < 8; p++)
      w2[23-3*p -: 3] = 3'(X[k][20+p]);
    wr(12'h508, w0);
    wr(12'h508, w1);
    wr(12'h508, w2);
    m_rows++;
  endtask

  task automatic model_start();
    while (can_run(m_next)) begin
      for (int c = 0; c < 28; c++)
        exp_mem[m_next*28+c] = conv(m_next, c);
      if (m_next == 27) m_cdone = 1;
      m_next++;
    end
    m_rdone = 1;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] rd; logic err;
    int n = 0;
    do begin
      xfer(1'b0, 12'h504, 32'd0, rd, err);
      n++;
    end while (rd[0] && n < 400);
    chk({tag, "_idle"}, {31'd0, rd[0]}, 32'd0);
    chk({tag, "_status"}, rd, {29'd0, m_cdone, m_rdone, 1'b0});
  endtask

  task automatic start_wait(input string tag);
    wr(12'h500, 32'd1);
    model_start();
    wait_idle(tag);
  endtask

  task automatic check_mem(input string tag, input int lo, input int hi);
    wr(12'h50C, 32'(lo));
    for (int a = lo; a <= hi; a++)
      rd_chk($sformatf("%s_res%0d", tag, a), 12'h510, 32'(exp_mem[a]));
  endtask

  task automatic fill(input int wv, input int xv);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) W[i][j] = wv;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) X[r][c] = xv;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, cap;
    logic [31:0] rd;
    logic err;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    HRESETn = 1'b1;
    for (int i = 0; i < 784; i++) exp_mem[i] = 0;
    repeat (3) @(negedge HCLK);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst_pready", {31'd0, PREADY}, 32'd1);
    HRESETn = 1'b0;
    rd_chk("rst_status", 12'h504, 32'd0);
    rd_chk("rst_ridx", 12'h50C, 32'd0);

    // all ones, rows 0-2 only
    fill(1, 1);
    load_filters();
    for (int k = 0; k < 3; k++) load_row(k);
    start_wait("ones");
    check_mem("ones", 0, 27);
    wr(12'h50C, 32'd0);
    rd_chk("ones_00", 12'h510, 32'd9);
    wr(12'h50C, 32'd2);
    rd_chk("ones_02", 12'h510, 32'd15);

    // start with too few rows
    load_filters();
    load_row(0);
    load_row(1);
    wr(12'h500, 32'd1);
    model_start();
    @(posedge HCLK);
    rd_chk("short_status", 12'h504, 32'd2);
    check_mem("short", 0, 27);

    // random filter and image, random loading cadence
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) W[i][j] = $urandom_range(0, 7);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) X[r][c] = $urandom_range(0, 7);
    load_filters();
    while (m_next <= 27) begin
      cap = (m_next + 6 > 28) ? 28 : m_next + 6;
      tgt = m_rows + $urandom_range(1, 3);
      if (tgt > cap) tgt = cap;
      while (m_rows < tgt) load_row(m_rows);
      start_wait("rnd");
    end
    wr(12'h50C, 32'd783);
    rd_chk("rnd_last", 12'h510, 32'(exp_mem[783]));
    rd_chk("ridx_wrap", 12'h50C, 32'd0);
    check_mem("rnd", 0, 783);

    // centre weight only; writes while busy must be ignored
    fill(0, 7);
    W[2][2] = 7;
    load_filters();
    for (int k = 0; k < 27; k++) begin
      load_row(k);
      if (k >= 2) start_wait("ctr");
    end
    load_row(27);
    wr(12'h500, 32'd1);
    model_start();
    rd_chk("busy_status", 12'h504, 32'd1);
    wr(12'h904, 32'd0);
    wr(12'h900, 32'd0);
    wait_idle("ctr_end");
    wr(12'h50C, 32'd400);
    rd_chk("ctr_400", 12'h510, 32'd49);
    check_mem("ctr", 0, 783);

    // all sevens; FILT0 after chan_done clears status
    fill(7, 7);
    load_filters();
    rd_chk("newchan_status", 12'h504, 32'd0);
    for (int k = 0; k < 5; k++) load_row(k);
    start_wait("sev");
    wr(12'h50C, 32'd58);
`ifdef APB_CONV_SATURATE_EN
    rd_chk("sev_22", 12'h510, 32'd255);
`else
    rd_chk("sev_22", 12'h510, 32'd201);
`endif
    check_mem("sev", 0, 83);

    // slave errors
    rd_chk("err_700", 12'h700, 32'h8000_0000);
    xfer(1'b1, 12'h504, 32'd7, rd, err);
    chk("err_wr_status", {31'd0, err}, 32'd1);
    rd_chk("err_rd_ctrl", 12'h500, 32'h8000_0000);
    rd_chk("err_rd_filt", 12'h904, 32'h8000_0000);
    rd_chk("ok_status", 12'h504, 32'd2);

    // reset mid-computation
    fill(1, 1);
    load_filters();
    for (int k = 0; k < 3; k++) load_row(k);
    wr(12'h500, 32'd1);
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    rd_chk("abort_status", 12'h504, 32'd0);
    rd_chk("abort_ridx", 12'h50C, 32'd0);
    repeat (60) @(negedge HCLK);
    rd_chk("abort_status2", 12'h504, 32'd0);
    check_mem("abort", 20, 83);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
